// File: rtl/pipeline_sr_ce_pkg.sv
// Shared helpers for the pipeline_sr_ce delay line.
// Width helper keeps degenerate sizes at one bit.
package pipeline_sr_ce_pkg;

    function automatic int clog2_min1(input int value);
        int r;
        r = $clog2(value);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/pipeline_sr_ce.sv
// Stallable, flushable delay line for time-multiplexed operator/channel slots,
// with per-stage valids, occupancy status and a registered debug tap.
module pipeline_sr_ce
    import pipeline_sr_ce_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 1,
    parameter int                    STARTING_CYCLE = 1,
    parameter int                    ENDING_CYCLE   = 1,
    parameter logic [DATA_WIDTH-1:0] POR_VALUE      = '0,
    parameter int                    TAP_W          = clog2_min1(ENDING_CYCLE + 1),
    localparam int                   DEPTH          = ENDING_CYCLE - STARTING_CYCLE + 1,
    localparam int                   OCC_W          = clog2_min1(DEPTH + 1)
) (
    input  logic                                              clk,
    input  logic                                              reset_n,
    input  logic                                              ce,
    input  logic                                              flush,
    input  logic [DATA_WIDTH-1:0]                             in,
    input  logic                                              in_valid,
    output logic [ENDING_CYCLE:STARTING_CYCLE][DATA_WIDTH-1:0] out,
    output logic [ENDING_CYCLE:STARTING_CYCLE]                out_valid,
    output logic [OCC_W-1:0]                                  occupancy,
    output logic                                              empty,
    output logic                                              full,
    input  logic [TAP_W-1:0]                                  tap_sel,
    output logic [DATA_WIDTH-1:0]                             tap_data,
    output logic                                              tap_valid
);

    logic [ENDING_CYCLE:STARTING_CYCLE][DATA_WIDTH-1:0] stage_d;
    logic [ENDING_CYCLE:STARTING_CYCLE]                 stage_v;
    logic [OCC_W-1:0]                                   occ;
    logic [OCC_W-1:0]                                   occ_next;
    logic [DATA_WIDTH-1:0]                              tap_d_p1;
    logic                                               tap_v_p1;
    logic                                               tap_hit;

    // A simultaneous entry and exit leaves the count unchanged.
    always_comb begin
        occ_next = occ;
        if (in_valid && !stage_v[ENDING_CYCLE]) begin
            occ_next = occ + 1'b1;
        end else if (!in_valid && stage_v[ENDING_CYCLE]) begin
            occ_next = occ - 1'b1;
        end
    end

    // Stage array: flush beats ce; bubbles still carry their data down the line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_d <= {DEPTH{POR_VALUE}};
            stage_v <= '0;
            occ     <= '0;
        end else if (flush) begin
            stage_d <= {DEPTH{POR_VALUE}};
            stage_v <= '0;
            occ     <= '0;
        end else if (ce) begin
            for (int k = ENDING_CYCLE; k > STARTING_CYCLE; k--) begin
                stage_d[k] <= stage_d[k-1];
                stage_v[k] <= stage_v[k-1];
            end
            stage_d[STARTING_CYCLE] <= in;
            stage_v[STARTING_CYCLE] <= in_valid;
            occ                     <= occ_next;
        end
    end

    assign tap_hit = (int'(tap_sel) >= STARTING_CYCLE) && (int'(tap_sel) <= ENDING_CYCLE);

    // Tap stage: samples every edge regardless of ce, so it lags the stages by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tap_d_p1 <= POR_VALUE;
            tap_v_p1 <= 1'b0;
        end else if (tap_hit) begin
            tap_d_p1 <= stage_d[tap_sel];
            tap_v_p1 <= stage_v[tap_sel];
        end else begin
            tap_d_p1 <= POR_VALUE;
            tap_v_p1 <= 1'b0;
        end
    end

    assign out       = stage_d;
    assign out_valid = stage_v;
    assign occupancy = occ;
    assign empty     = (occ == '0);
    assign full      = (occ == OCC_W'(DEPTH));
    assign tap_data  = tap_d_p1;
    assign tap_valid = tap_v_p1;

    occ_in_range: assert property (@(posedge clk) disable iff (!reset_n) occ <= OCC_W'(DEPTH));

endmodule
